ibex_id_instr_tracker: RTL and testbench
========================================

# ibex_id_instr_tracker

Synthesizable tracker that sits directly downstream of the ID-stage instruction probe points. It converts the per-cycle ID-stage signals into one record per instruction, with a stall-cycle count and branch/jump outcome, and buffers the records in a small FIFO drained by a valid/ready trace consumer. Drops, overflow and RVFI order gaps are flagged so the DV environment can tell when trace data was lost.

## Interface
- DATA_WIDTH, 32, width of instruction, PC and branch-target fields
- DEPTH, 4, FIFO entries; power of two, >= 2
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- valid_id_i  in  1  ID stage holds a valid instruction
- instr_new_id_i  in  1  instruction entered ID this cycle
- err_id_i  in  1  fetch error on ID instruction
- is_compressed_id_i  in  1  ID instruction is compressed
- instr_compressed_id_i  in  16  raw compressed encoding
- instr_id_i  in  DATA_WIDTH  decompressed instruction
- pc_id_i  in  DATA_WIDTH  ID PC
- branch_taken_id_i  in  1  branch taken in ID
- branch_target_id_i  in  DATA_WIDTH  branch/jump target
- stall_id_i  in  1  ID stalled
- jump_set_id_i  in  1  jump target set in ID
- rvfi_order_id_i  in  64  RVFI order of ID instruction
- rec_valid_o  out  1  record available
- rec_ready_i  in  1  consumer accepts record
- rec_pc_o, rec_instr_o, rec_target_o  out  DATA_WIDTH each  PC, instruction (compressed: {16'h0, raw}), target
- rec_compressed_o, rec_err_o, rec_taken_o  out  1 each  compressed, error, branch taken or jump set
- rec_order_o  out  64  RVFI order
- rec_stall_cycles_o  out  16  stalled cycles while held
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy
- overflow_o  out  1  sticky: a record was dropped
- drop_count_o  out  16  dropped records, saturating
- order_gap_o  out  1  sticky: pushed order != previous pushed order + 1

## Operation
- Capture FSM: IDLE, HELD.
- Open: valid_id_i && instr_new_id_i at an edge -> latch pc, instr, compressed, err, order, taken = branch_taken|jump_set, target = branch_target_id_i if taken; stall count = 0; state HELD.
- While HELD, at each non-closing edge: stall count += stall_id_i (saturate 16'hFFFF); err |= err_id_i; if !taken and (branch_taken_id_i|jump_set_id_i) then taken = 1, target captured (first assertion wins).
- Close: HELD and (instr_new_id_i || !valid_id_i). Held record pushed; fields at the closing edge are not merged. If instr_new_id_i && valid_id_i at the same edge, the new instruction opens (stays HELD); otherwise go IDLE.
- instr_new_id_i with valid_id_i low is ignored.
- FIFO push on close. Full and no pop at the same edge: record dropped, overflow_o set, drop_count_o += 1 (saturate). Full with pop at the same edge: push accepted, level unchanged.
- Pop: rec_valid_o && rec_ready_i. Outputs reflect the head entry; rec_valid_o = level_o != 0.
- order_gap_o: compare each accepted push with the last accepted push order (64-bit wrap). The first push after reset is never a gap. Dropped records do not update the reference, so a drop causes a gap on the next accepted push.

## Timing
- Reset: FSM IDLE, FIFO empty, rec_valid_o = 0, level_o = 0, overflow_o = 0, order_gap_o = 0, drop_count_o = 0, all record outputs 0.
- Reset mid-operation discards the held record and all FIFO contents immediately (asynchronous).
- Close edge N -> rec_valid_o high after edge N if the FIFO was empty (one-cycle latency). No combinational path from ID inputs to rec_* outputs.
- Outputs hold stable while rec_valid_o && !rec_ready_i.
- Pointers wrap modulo DEPTH; full = level_o == DEPTH.

## Test plan
- Single instr: new at pc 0x80, stall high 3 cycles, then valid drop -> one record, pc 0x80, stall_cycles 3, taken 0, level 1 then 0 after ready.
- Back-to-back: instr_new on 3 consecutive cycles, orders 5,6,7, then valid low -> 3 records in order 5,6,7, stall 0 each, order_gap_o 0.
- Compressed branch: compressed 16'h8082; branch_taken at the second held cycle with target 0x200, then a second assertion with 0x300 -> rec_instr 32'h00008082, compressed 1, taken 1, target 0x200.
- Overflow: rec_ready_i 0, DEPTH+2 instructions closed -> level DEPTH, overflow_o 1, drop_count 2, next accepted push sets order_gap_o; with full FIFO plus simultaneous pop and push, level stays DEPTH and no drop occurs.
- Stall saturation: stall held for 70000 cycles -> rec_stall_cycles_o 16'hFFFF.
- Reset mid-record: assert rst_ni low while HELD with 2 records queued -> rec_valid_o 0 and level 0 immediately; after release, no stale record emitted.

Source files
------------

// File: rtl/ibex_id_instr_tracker_if.sv
// ibex_id_instr_tracker_if
//
// Bundles the ID-stage probe signals (into the tracker) and the trace record
// channel plus status (out of the tracker). Clock and reset stay plain ports
// on the modules that use this interface.
//
// Modports:
//   slave  - tracker view: ID probe inputs and rec_ready_i in, records/status out
//   master - environment view: drives the ID probe and rec_ready_i, observes records
//
// Record channel handshake: a record transfers on a clock edge where
// rec_valid_o && rec_ready_i. rec_valid_o never depends combinationally on
// rec_ready_i, and the record fields hold stable while rec_valid_o is high
// and rec_ready_i is low.
interface ibex_id_instr_tracker_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    // ID-stage probe
    logic                  valid_id_i;
    logic                  instr_new_id_i;
    logic                  err_id_i;
    logic                  is_compressed_id_i;
    logic [15:0]           instr_compressed_id_i;
    logic [DATA_WIDTH-1:0] instr_id_i;
    logic [DATA_WIDTH-1:0] pc_id_i;
    logic                  branch_taken_id_i;
    logic [DATA_WIDTH-1:0] branch_target_id_i;
    logic                  stall_id_i;
    logic                  jump_set_id_i;
    logic [63:0]           rvfi_order_id_i;

    // Record channel
    logic                  rec_valid_o;
    logic                  rec_ready_i;
    logic [DATA_WIDTH-1:0] rec_pc_o;
    logic [DATA_WIDTH-1:0] rec_instr_o;
    logic [DATA_WIDTH-1:0] rec_target_o;
    logic                  rec_compressed_o;
    logic                  rec_err_o;
    logic                  rec_taken_o;
    logic [63:0]           rec_order_o;
    logic [15:0]           rec_stall_cycles_o;

    // Status
    logic [LW-1:0]         level_o;
    logic                  overflow_o;
    logic [15:0]           drop_count_o;
    logic                  order_gap_o;

    modport slave (
        input  valid_id_i, instr_new_id_i, err_id_i, is_compressed_id_i,
               instr_compressed_id_i, instr_id_i, pc_id_i, branch_taken_id_i,
               branch_target_id_i, stall_id_i, jump_set_id_i, rvfi_order_id_i,
               rec_ready_i,
        output rec_valid_o, rec_pc_o, rec_instr_o, rec_target_o,
               rec_compressed_o, rec_err_o, rec_taken_o, rec_order_o,
               rec_stall_cycles_o, level_o, overflow_o, drop_count_o,
               order_gap_o
    );

    modport master (
        output valid_id_i, instr_new_id_i, err_id_i, is_compressed_id_i,
               instr_compressed_id_i, instr_id_i, pc_id_i, branch_taken_id_i,
               branch_target_id_i, stall_id_i, jump_set_id_i, rvfi_order_id_i,
               rec_ready_i,
        input  rec_valid_o, rec_pc_o, rec_instr_o, rec_target_o,
               rec_compressed_o, rec_err_o, rec_taken_o, rec_order_o,
               rec_stall_cycles_o, level_o, overflow_o, drop_count_o,
               order_gap_o
    );
endinterface

// File: rtl/ibex_id_instr_tracker.sv
// ibex_id_instr_tracker
//
// Turns per-cycle ID-stage probe signals into one record per instruction
// (PC, instruction, error, RVFI order, branch/jump outcome, stall-cycle
// count) and queues the records in a DEPTH-entry FIFO drained over a
// valid/ready channel. Dropped records, overflow and RVFI order gaps are
// flagged so lost trace data is visible.
//
// Ports:
//   clk_i       - clock
//   rst_ni      - asynchronous active-low reset
//   trk         - ibex_id_instr_tracker_if.slave (ID probe, record channel, status)
//   state_dbg_o - capture FSM state (0 = IDLE, 1 = HELD)
module ibex_id_instr_tracker #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    ibex_id_instr_tracker_if.slave   trk,
    output logic                     state_dbg_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
        logic [DATA_WIDTH-1:0] target;
        logic                  comp;
        logic                  err;
        logic                  taken;
        logic [63:0]           order;
        logic [15:0]           stall;
    } rec_t;

    state_e         state_q;
    rec_t           held_q;
    rec_t           new_rec;

    rec_t           mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [LW-1:0]  count_q;
    logic [63:0]    last_order_q;
    logic           have_ref_q;
    logic           overflow_q;
    logic [15:0]    drop_cnt_q;
    logic           gap_q;

    logic           id_open;
    logic           id_close;
    logic           id_taken;
    logic           fifo_full;
    logic           rec_valid;
    logic           pop;
    logic           push_ok;
    logic           drop;
    rec_t           head;

    // ------------------------------------------------------------------
    // Capture side
    // ------------------------------------------------------------------
    assign id_open  = trk.valid_id_i && trk.instr_new_id_i;
    assign id_close = (state_q == ST_HELD) && (trk.instr_new_id_i || !trk.valid_id_i);
    assign id_taken = trk.branch_taken_id_i || trk.jump_set_id_i;

    // Record image of the instruction entering ID this cycle.
    always_comb begin
        new_rec        = '0;
        new_rec.pc     = trk.pc_id_i;
        new_rec.instr  = trk.is_compressed_id_i
                       ? {{(DATA_WIDTH-16){1'b0}}, trk.instr_compressed_id_i}
                       : trk.instr_id_i;
        new_rec.comp   = trk.is_compressed_id_i;
        new_rec.err    = trk.err_id_i;
        new_rec.order  = trk.rvfi_order_id_i;
        new_rec.taken  = id_taken;
        new_rec.target = id_taken ? trk.branch_target_id_i : '0;
        new_rec.stall  = 16'h0000;
    end

    // Capture FSM. On a closing edge the held record goes to the FIFO as-is;
    // the probe values present at that edge belong to the next instruction
    // (or to nothing) and are not merged into it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            held_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (id_open) begin
                        held_q  <= new_rec;
                        state_q <= ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (id_close) begin
                        if (id_open) begin
                            held_q <= new_rec;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        if (trk.stall_id_i && (held_q.stall != 16'hFFFF)) begin
                            held_q.stall <= held_q.stall + 16'd1;
                        end
                        if (trk.err_id_i) begin
                            held_q.err <= 1'b1;
                        end
                        // First branch/jump assertion wins; later ones are ignored.
                        if (!held_q.taken && id_taken) begin
                            held_q.taken  <= 1'b1;
                            held_q.target <= trk.branch_target_id_i;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign state_dbg_o = state_q;

    // ------------------------------------------------------------------
    // Record FIFO
    // ------------------------------------------------------------------
    assign fifo_full = (count_q == LW'(DEPTH));
    assign rec_valid = (count_q != '0);
    assign pop       = rec_valid && trk.rec_ready_i;
    // A pop in the same edge frees the slot, so a full FIFO still accepts.
    assign push_ok   = id_close && (!fifo_full || pop);
    assign drop      = id_close && fifo_full && !pop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            last_order_q <= '0;
            have_ref_q   <= 1'b0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= '0;
            gap_q        <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= held_q;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
                // Reference only advances on accepted pushes, so a drop shows
                // up as a gap on the next push that makes it in.
                if (have_ref_q && (held_q.order != last_order_q + 64'd1)) begin
                    gap_q <= 1'b1;
                end
                last_order_q <= held_q.order;
                have_ref_q   <= 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + LW'(1);
                2'b01:   count_q <= count_q - LW'(1);
                default: count_q <= count_q;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_q <= drop_cnt_q + 16'd1;
                end
            end
        end
    end

    // Record fields read zero whenever nothing is queued.
    assign head = rec_valid ? mem_q[rd_ptr_q] : '0;

    assign trk.rec_valid_o        = rec_valid;
    assign trk.rec_pc_o           = head.pc;
    assign trk.rec_instr_o        = head.instr;
    assign trk.rec_target_o       = head.target;
    assign trk.rec_compressed_o   = head.comp;
    assign trk.rec_err_o          = head.err;
    assign trk.rec_taken_o        = head.taken;
    assign trk.rec_order_o        = head.order;
    assign trk.rec_stall_cycles_o = head.stall;
    assign trk.level_o            = count_q;
    assign trk.overflow_o         = overflow_q;
    assign trk.drop_count_o       = drop_cnt_q;
    assign trk.order_gap_o        = gap_q;

endmodule

// File: tb/tb_ibex_id_instr_tracker.sv
module tb_ibex_id_instr_tracker;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;

  logic clk_i;
  logic rst_ni;
  logic state_dbg;

  int pass_cnt;
  int total_cnt;

  logic [63:0] exp_q[$];

  ibex_id_instr_tracker_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  ibex_id_instr_tracker #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .trk         (bus),
    .state_dbg_o (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.valid_id_i            = 1'b0;
    bus.instr_new_id_i        = 1'b0;
    bus.err_id_i              = 1'b0;
    bus.is_compressed_id_i    = 1'b0;
    bus.instr_compressed_id_i = 16'h0;
    bus.instr_id_i            = '0;
    bus.pc_id_i               = '0;
    bus.branch_taken_id_i     = 1'b0;
    bus.branch_target_id_i    = '0;
    bus.stall_id_i            = 1'b0;
    bus.jump_set_id_i         = 1'b0;
    bus.rvfi_order_id_i       = '0;
    bus.rec_ready_i           = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic open_instr(input logic [DW-1:0] pc, input logic [DW-1:0] instr,
                            input logic [63:0] order);
    bus.valid_id_i         = 1'b1;
    bus.instr_new_id_i     = 1'b1;
    bus.is_compressed_id_i = 1'b0;
    bus.pc_id_i            = pc;
    bus.instr_id_i         = instr;
    bus.rvfi_order_id_i    = order;
    bus.stall_id_i         = 1'b0;
    bus.err_id_i           = 1'b0;
    bus.branch_taken_id_i  = 1'b0;
    bus.jump_set_id_i      = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst_ni = 1'b0;
    repeat (2) tick();
    total_cnt++;
    if (bus.rec_valid_o !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", bus.rec_valid_o);
    else pass_cnt++;
    total_cnt++;
    if (bus.level_o !== 3'd0) $display("FAIL reset_level got=%0d exp=0", bus.level_o);
    else pass_cnt++;
    total_cnt++;
    if ({bus.overflow_o, bus.order_gap_o, bus.drop_count_o} !== 18'd0)
      $display("FAIL reset_status got=%0b/%0b/%0d exp=0/0/0", bus.overflow_o, bus.order_gap_o, bus.drop_count_o);
    else pass_cnt++;
    total_cnt++;
    if ({bus.rec_pc_o, bus.rec_instr_o, bus.rec_target_o, bus.rec_order_o, bus.rec_stall_cycles_o} !== '0)
      $display("FAIL reset_record got_pc=%h got_order=%h exp=0", bus.rec_pc_o, bus.rec_order_o);
    else pass_cnt++;
    total_cnt++;
    if (state_dbg !== 1'b0) $display("FAIL reset_state got=%0b exp=0", state_dbg);
    else pass_cnt++;
    rst_ni = 1'b1;
    tick();
    total_cnt++;
    if (bus.rec_valid_o !== 1'b0) $display("FAIL reset_release_valid got=%0b exp=0", bus.rec_valid_o);
    else pass_cnt++;
  endtask

  task automatic test_single();
    apply_reset();
    open_instr(32'h80, 32'h00000013, 64'd1);
    tick();
    bus.instr_new_id_i = 1'b0;
    bus.stall_id_i     = 1'b1;
    repeat (3) tick();
    // stall stays high on the closing edge; it must not be counted
    bus.valid_id_i = 1'b0;
    total_cnt++;
    if (bus.level_o !== 3'd0) $display("FAIL single_pre_close_level got=%0d exp=0", bus.level_o);
    else pass_cnt++;
    tick();
    bus.stall_id_i = 1'b0;
    total_cnt++;
    if (bus.rec_valid_o !== 1'b1 || bus.level_o !== 3'd1)
      $display("FAIL single_level got=%0b/%0d exp=1/1", bus.rec_valid_o, bus.level_o);
    else pass_cnt++;
    total_cnt++;
    if (bus.rec_pc_o !== 32'h80 || bus.rec_instr_o !== 32'h13 || bus.rec_order_o !== 64'd1)
      $display("FAIL single_fields got=%h/%h/%0d exp=80/13/1", bus.rec_pc_o, bus.rec_instr_o, bus.rec_order_o);
    else pass_cnt++;
    total_cnt++;
    if (bus.rec_stall_cycles_o !== 16'd3) $display("FAIL single_stall got=%0d exp=3", bus.rec_stall_cycles_o);
    else pass_cnt++;
    total_cnt++;
    if (bus.rec_taken_o !== 1'b0 || bus.rec_compressed_o !== 1'b0 || bus.rec_err_o !== 1'b0)
      $display("FAIL single_flags got=%0b%0b%0b exp=000", bus.rec_taken_o, bus.rec_compressed_o, bus.rec_err_o);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.rec_pc_o !== 32'h80 || bus.level_o !== 3'd1)
      $display("FAIL single_hold got=%h/%0d exp=80/1", bus.rec_pc_o, bus.level_o);
    else pass_cnt++;
    bus.rec_ready_i = 1'b1;
    tick();
    bus.rec_ready_i = 1'b0;
    total_cnt++;
    if (bus.rec_valid_o !== 1'b0 || bus.level_o !== 3'd0)
      $display("FAIL single_drain got=%0b/%0d exp=0/0", bus.rec_valid_o, bus.level_o);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    open_instr(32'h100, 32'h00100093, 64'd5); tick();
    open_instr(32'h104, 32'h00200113, 64'd6); tick();
    open_instr(32'h108, 32'h00300193, 64'd7); tick();
    bus.valid_id_i     = 1'b0;
    bus.instr_new_id_i = 1'b0;
    tick();
    total_cnt++;
    if (bus.level_o !== 3'd3) $display("FAIL b2b_level got=%0d exp=3", bus.level_o);
    else pass_cnt++;
    bus.rec_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (bus.rec_order_o !== 64'(5 + i) || bus.rec_stall_cycles_o !== 16'd0 ||
          bus.rec_pc_o !== 32'(32'h100 + 4 * i))
        $display("FAIL b2b_rec%0d got=%0d/%0d/%h exp=%0d/0/%h", i, bus.rec_order_o,
                 bus.rec_stall_cycles_o, bus.rec_pc_o, 5 + i, 32'h100 + 4 * i);
      else pass_cnt++;
      tick();
    end
    bus.rec_ready_i = 1'b0;
    total_cnt++;
    if (bus.level_o !== 3'd0 || bus.order_gap_o !== 1'b0)
      $display("FAIL b2b_end got=%0d/%0b exp=0/0", bus.level_o, bus.order_gap_o);
    else pass_cnt++;
  endtask

  task automatic test_compressed_branch();
    apply_reset();
    open_instr(32'h40, 32'h00008067, 64'd9);
    bus.is_compressed_id_i    = 1'b1;
    bus.instr_compressed_id_i = 16'h8082;
    tick();
    bus.instr_new_id_i     = 1'b0;
    bus.is_compressed_id_i = 1'b0;
    bus.err_id_i           = 1'b1;
    tick();
    bus.err_id_i           = 1'b0;
    bus.branch_taken_id_i  = 1'b1;
    bus.branch_target_id_i = 32'h200;
    tick();
    bus.branch_target_id_i = 32'h300;
    tick();
    bus.branch_taken_id_i = 1'b0;
    bus.valid_id_i        = 1'b0;
    tick();
    total_cnt++;
    if (bus.rec_instr_o !== 32'h00008082 || bus.rec_compressed_o !== 1'b1)
      $display("FAIL cbr_instr got=%h/%0b exp=00008082/1", bus.rec_instr_o, bus.rec_compressed_o);
    else pass_cnt++;
    total_cnt++;
    if (bus.rec_taken_o !== 1'b1 || bus.rec_target_o !== 32'h200)
      $display("FAIL cbr_target got=%0b/%h exp=1/00000200", bus.rec_taken_o, bus.rec_target_o);
    else pass_cnt++;
    total_cnt++;
    if (bus.rec_err_o !== 1'b1 || bus.rec_pc_o !== 32'h40 || bus.rec_order_o !== 64'd9)
      $display("FAIL cbr_fields got=%0b/%h/%0d exp=1/40/9", bus.rec_err_o, bus.rec_pc_o, bus.rec_order_o);
    else pass_cnt++;
    bus.rec_ready_i = 1'b1;
    tick();
    bus.rec_ready_i = 1'b0;
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < DEPTH + 2; i++) begin
      open_instr(32'(32'h1000 + 4 * i), 32'h00000013, 64'(10 + i));
      tick();
    end
    bus.valid_id_i     = 1'b0;
    bus.instr_new_id_i = 1'b0;
    tick();
    total_cnt++;
    if (bus.level_o !== 3'(DEPTH) || bus.overflow_o !== 1'b1 || bus.drop_count_o !== 16'd2)
      $display("FAIL ovf_full got=%0d/%0b/%0d exp=%0d/1/2", bus.level_o, bus.overflow_o, bus.drop_count_o, DEPTH);
    else pass_cnt++;
    total_cnt++;
    if (bus.order_gap_o !== 1'b0) $display("FAIL ovf_nogap got=%0b exp=0", bus.order_gap_o);
    else pass_cnt++;
    // full FIFO: pop and push at the same edge
    open_instr(32'h2000, 32'h00000013, 64'd16);
    tick();
    bus.valid_id_i     = 1'b0;
    bus.instr_new_id_i = 1'b0;
    bus.rec_ready_i    = 1'b1;
    tick();
    bus.rec_ready_i = 1'b0;
    total_cnt++;
    if (bus.level_o !== 3'(DEPTH) || bus.drop_count_o !== 16'd2)
      $display("FAIL ovf_poppush got=%0d/%0d exp=%0d/2", bus.level_o, bus.drop_count_o, DEPTH);
    else pass_cnt++;
    total_cnt++;
    if (bus.order_gap_o !== 1'b1) $display("FAIL ovf_gap got=%0b exp=1", bus.order_gap_o);
    else pass_cnt++;
    exp_q.push_back(64'd11);
    exp_q.push_back(64'd12);
    exp_q.push_back(64'd13);
    exp_q.push_back(64'd16);
    bus.rec_ready_i = 1'b1;
    while (exp_q.size() > 0) begin
      logic [63:0] exp_order;
      exp_order = exp_q.pop_front();
      total_cnt++;
      if (bus.rec_valid_o !== 1'b1 || bus.rec_order_o !== exp_order)
        $display("FAIL ovf_drain got=%0b/%0d exp=1/%0d", bus.rec_valid_o, bus.rec_order_o, exp_order);
      else pass_cnt++;
      tick();
    end
    bus.rec_ready_i = 1'b0;
    total_cnt++;
    if (bus.level_o !== 3'd0) $display("FAIL ovf_empty got=%0d exp=0", bus.level_o);
    else pass_cnt++;
  endtask

  task automatic test_stall_saturation();
    apply_reset();
    open_instr(32'h300, 32'h00000013, 64'd1);
    tick();
    bus.instr_new_id_i = 1'b0;
    bus.stall_id_i     = 1'b1;
    repeat (70000) tick();
    bus.stall_id_i = 1'b0;
    bus.valid_id_i = 1'b0;
    tick();
    total_cnt++;
    if (bus.rec_valid_o !== 1'b1 || bus.rec_stall_cycles_o !== 16'hFFFF)
      $display("FAIL stall_sat got=%0b/%h exp=1/ffff", bus.rec_valid_o, bus.rec_stall_cycles_o);
    else pass_cnt++;
    bus.rec_ready_i = 1'b1;
    tick();
    bus.rec_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid_record();
    apply_reset();
    open_instr(32'h400, 32'h00000013, 64'd1); tick();
    open_instr(32'h404, 32'h00000013, 64'd2); tick();
    open_instr(32'h408, 32'h00000013, 64'd3); tick();
    bus.instr_new_id_i = 1'b0;
    tick();
    total_cnt++;
    if (bus.level_o !== 3'd2 || state_dbg !== 1'b1)
      $display("FAIL rstmid_pre got=%0d/%0b exp=2/1", bus.level_o, state_dbg);
    else pass_cnt++;
    #2;
    rst_ni = 1'b0;
    #1;
    total_cnt++;
    if (bus.rec_valid_o !== 1'b0 || bus.level_o !== 3'd0 || state_dbg !== 1'b0)
      $display("FAIL rstmid_async got=%0b/%0d/%0b exp=0/0/0", bus.rec_valid_o, bus.level_o, state_dbg);
    else pass_cnt++;
    bus.valid_id_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    bus.rec_ready_i = 1'b1;
    repeat (3) tick();
    bus.rec_ready_i = 1'b0;
    total_cnt++;
    if (bus.rec_valid_o !== 1'b0 || bus.level_o !== 3'd0 || bus.rec_order_o !== 64'd0)
      $display("FAIL rstmid_stale got=%0b/%0d/%0d exp=0/0/0", bus.rec_valid_o, bus.level_o, bus.rec_order_o);
    else pass_cnt++;
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_ni    = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_back_to_back();
    test_compressed_branch();
    test_overflow();
    test_stall_saturation();
    test_reset_mid_record();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
